servo_pos_ramp: RTL and testbench
=================================

// Module: servo_pos_ramp
// PURPOSE
//  Upstream stage of the PWM servo driver. Produces the 8-bit position word (pos_out) that feeds the PWM entradaPWM input.
//  Target position arrives via a valid/ready command or via up/down buttons; target is clamped to [POS_MIN,POS_MAX].
//  pos_out slews toward the target by STEP units once every TICK_DIV clocks, so the servo never jumps.
// PARAMETERS
//  TICK_DIV   100000  clocks per ramp tick (>=2)
//  STEP       1       position units moved per tick (1..POS_MAX-POS_MIN)
//  POS_MIN    0       lowest legal position
//  POS_MAX    250     highest legal position (<=250: 250*40 = 10000 = full PWM period)
//  RESET_POS  125     pos_out/target after reset (POS_MIN<=RESET_POS<=POS_MAX)
// PORTS
//  clock      in   1  system clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  absolute position command valid
//  cmd_pos    in   8  commanded position (clamped, never rejected)
//  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
//  btn_up     in   1  level, pre-synchronised; nudge target +STEP per tick
//  btn_dn     in   1  level, pre-synchronised; nudge target -STEP per tick
//  pos_out    out  8  current position word to PWM (registered)
//  busy       out  1  1 while state==RAMP
//  at_target  out  1  pos_out == target (decoded from registers)
// BEHAVIOUR
//  Reset: pos_out=RESET_POS, target=RESET_POS, tick_cnt=0, state=IDLE, cmd_ready=0 while rst high, busy=0, at_target=1.
//  Tick: tick_cnt counts 0..TICK_DIV-1, wraps and is free-running from reset; tick=1 in the cycle tick_cnt==TICK_DIV-1.
//  Target update, priority order:
//   1. Handshake accepted in cycle N: target=clamp(cmd_pos) at N+1.
//   2. Else on tick, btn_up&!btn_dn: target=min(target+STEP,POS_MAX).
//   3. Else on tick, btn_dn&!btn_up: target=max(target-STEP,POS_MIN).
//   Both buttons or neither: target unchanged. Buttons act in both states.
//  Arithmetic: all add/sub/compare in 9 bits; no 8-bit wrap at 0 or 255.
//  FSM (2 states):
//   IDLE -> RAMP the cycle after target != pos_out is registered.
//   RAMP, on tick: pos_out<target: pos_out=min(pos_out+STEP,target).
//   RAMP, on tick: pos_out>target: pos_out=max(pos_out-STEP,target).
//   RAMP -> IDLE the cycle after pos_out==target.
//   pos_out changes only on a tick while in RAMP.
//  Latency: cmd accepted at N -> target at N+1 -> RAMP at N+2 -> first step on first tick >= N+2.
//  cmd_ready: 1 in IDLE and rst low; 0 in RAMP (see CONFIGURATION).
//  Command equal to the current pos_out: accepted, FSM stays IDLE.
//  Reset mid-ramp: next cycle all state returns to reset values; any pending command is dropped.
// CONFIGURATION
//  SERVO_RAMP_PREEMPT_EN defined: cmd_ready=1 whenever rst low, including RAMP.
//   New target takes effect at N+1; ramp direction re-evaluated on the next tick, no return to IDLE.
//  Undefined: cmd_ready=0 in RAMP; the command waits for IDLE.
//   Buttons still retarget during RAMP in both builds.
// TESTING (TICK_DIV=4, STEP=1, defaults otherwise)
//  1. Release rst -> pos_out=125, busy=0, at_target=1, cmd_ready=1 on first non-reset cycle.
//  2. cmd 130 -> busy=1, cmd_ready=0, pos_out 126..130 on successive ticks (every 4 clk), then IDLE, at_target=1.
//  3. cmd 255 -> target clamped to 250, pos_out stops at 250; with POS_MIN=20, cmd 0 -> stops at 20.
//  4. btn_up held 3 ticks from 125 -> target 128, pos_out follows to 128; both buttons held -> target stays 128.
//  5. rst asserted at pos_out=127 mid-ramp -> next cycle pos_out=125, busy=0, tick_cnt=0.
//  6. cmd 200, then cmd_valid 100 at pos_out=130:
//     PREEMPT_EN build -> accepted at once, pos_out falls 130->100.
//     Default build -> cmd_ready=0 until pos_out=200, then accepted, falls to 100.

Source files
------------

// File: rtl/servo_pos_ramp.sv
// servo_pos_ramp: slews an 8-bit servo position word toward a clamped target.
// The target comes from a valid/ready command or from up/down buttons. The
// position moves by STEP once per ramp tick (every TICK_DIV clocks).
// Optional feature macro: SERVO_RAMP_PREEMPT_EN. When it is defined, commands
// are also accepted during a ramp and retarget the motion in flight.
module servo_pos_ramp #(
  parameter int TICK_DIV  = 100000,
  parameter int STEP      = 1,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 250,
  parameter int RESET_POS = 125
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_pos,
  output logic       cmd_ready,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [7:0] pos_out,
  output logic       busy,
  output logic       at_target
);

  localparam int              CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [8:0]      MIN9      = 9'(POS_MIN);
  localparam logic [8:0]      MAX9      = 9'(POS_MAX);
  localparam logic [8:0]      STEP9     = 9'(STEP);
  localparam logic [7:0]      RST8      = 8'(RESET_POS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       pos_q, pos_d;
  logic             tick_s;
  logic             accept_s;
  logic [8:0]       tgt9_s;
  logic [8:0]       pos9_s;

  // Clamp a 9-bit value into the legal position window.
  function automatic logic [7:0] clamp_pos(input logic [8:0] v);
    logic [8:0] r;
    if (v > MAX9) begin
      r = MAX9;
    end else if (v < MIN9) begin
      r = MIN9;
    end else begin
      r = v;
    end
    return r[7:0];
  endfunction

  assign tgt9_s    = {1'b0, target_q};
  assign pos9_s    = {1'b0, pos_q};
  assign tick_s    = (tick_cnt_q == TICK_LAST);
  assign accept_s  = cmd_valid & cmd_ready;
  assign pos_out   = pos_q;
  assign busy      = (state_q == ST_RAMP);
  assign at_target = (pos_q == target_q);

  // Command acceptance: outside reset, and (unless preemption is built in) only when idle.
  always_comb begin
`ifdef SERVO_RAMP_PREEMPT_EN
    cmd_ready = ~rst;
`else
    cmd_ready = ~rst & (state_q == ST_IDLE);
`endif
  end

  // Free-running ramp tick divider.
  always_comb begin
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_ONE;
    end
  end

  // Target update: command first, then a single button per tick; 9-bit saturating math.
  always_comb begin
    target_d = target_q;
    if (accept_s) begin
      target_d = clamp_pos({1'b0, cmd_pos});
    end else if (tick_s && btn_up && !btn_dn) begin
      if ((tgt9_s + STEP9) > MAX9) begin
        target_d = MAX9[7:0];
      end else begin
        target_d = 8'(tgt9_s + STEP9);
      end
    end else if (tick_s && btn_dn && !btn_up) begin
      if (tgt9_s < (MIN9 + STEP9)) begin
        target_d = MIN9[7:0];
      end else begin
        target_d = 8'(tgt9_s - STEP9);
      end
    end else begin
      target_d = target_q;
    end
  end

  // Ramp FSM: leave IDLE once target differs, step on ticks, return when position arrives.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (target_q != pos_q) begin
          state_d = ST_RAMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (pos_q == target_q) begin
          state_d = ST_IDLE;
        end else if (tick_s && (pos_q < target_q)) begin
          if ((pos9_s + STEP9) > tgt9_s) begin
            pos_d = target_q;
          end else begin
            pos_d = 8'(pos9_s + STEP9);
          end
        end else if (tick_s) begin
          if (pos9_s < (tgt9_s + STEP9)) begin
            pos_d = target_q;
          end else begin
            pos_d = 8'(pos9_s - STEP9);
          end
        end else begin
          pos_d = pos_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pos_d   = pos_q;
      end
    endcase
  end

  // State registers with synchronous reset; a reset drops any pending command.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      target_q   <= RST8;
      pos_q      <= RST8;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      target_q   <= target_d;
      pos_q      <= pos_d;
    end
  end

endmodule

// File: tb/tb_servo_pos_ramp.sv
// Scoreboard bench for servo_pos_ramp (TICK_DIV=4, STEP=1).
// Every expected pos_out value is queued by the stimulus; a monitor pops and
// compares one entry each time pos_out changes.
module tb_servo_pos_ramp;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid0 = 1'b0;
  logic [7:0] cmd_pos0 = 8'd0;
  logic       cmd_ready0;
  logic       btn_up0 = 1'b0;
  logic       btn_dn0 = 1'b0;
  logic [7:0] pos0;
  logic       busy0, at0;

  logic       c1_valid = 1'b0;
  logic [7:0] c1_pos = 8'd0;
  logic       c1_ready;
  logic [7:0] pos1;
  logic       busy1, at1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  servo_pos_ramp #(.TICK_DIV(4), .STEP(1)) u0 (
    .clock(clock), .rst(rst), .cmd_valid(cmd_valid0), .cmd_pos(cmd_pos0),
    .cmd_ready(cmd_ready0), .btn_up(btn_up0), .btn_dn(btn_dn0),
    .pos_out(pos0), .busy(busy0), .at_target(at0)
  );

  servo_pos_ramp #(.TICK_DIV(4), .STEP(1), .POS_MIN(20)) u1 (
    .clock(clock), .rst(rst), .cmd_valid(c1_valid), .cmd_pos(c1_pos),
    .cmd_ready(c1_ready), .btn_up(1'b0), .btn_dn(1'b0),
    .pos_out(pos1), .busy(busy1), .at_target(at1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_range(input int from_v, input int to_v);
    if (from_v <= to_v) begin
      for (int v = from_v; v <= to_v; v++) exp_q.push_back(8'(v));
    end else begin
      for (int v = from_v; v >= to_v; v--) exp_q.push_back(8'(v));
    end
  endtask

  // Monitor: pops one expected value on every pos_out change.
  task automatic monitor();
    logic [7:0] prev;
    logic [7:0] e;
    prev = pos0;
    forever begin
      @(negedge clock);
      if (pos0 !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pos_unexpected actual=%0d required=no_change", pos0);
        end else begin
          e = exp_q.pop_front();
          if (pos0 !== e) begin
            n_fail++;
            $display("FAIL pos_seq actual=%0d required=%0d", pos0, e);
          end
        end
        prev = pos0;
      end
    end
  endtask

  // Called at a negedge; holds cmd_valid until the handshake completes.
  task automatic send_cmd(input logic [7:0] p);
    int cnt;
    cnt = 0;
    cmd_pos0   = p;
    cmd_valid0 = 1'b1;
    while (!cmd_ready0 && cnt < 3000) begin
      @(negedge clock);
      cnt++;
    end
    check("cmd_accept_in_time", {31'd0, cmd_ready0}, 32'd1);
    @(posedge clock);
    #1;
    cmd_valid0 = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_pos(input logic [7:0] v, output int cycles);
    cycles = 0;
    while (pos0 !== v && cycles < 3000) begin
      @(negedge clock);
      cycles++;
    end
    check("reach_pos", {24'd0, pos0}, {24'd0, v});
  endtask

  task automatic wait_idle(input logic [7:0] v);
    int cnt;
    cnt = 0;
    while (!(pos0 === v && busy0 === 1'b0) && cnt < 3000) begin
      @(negedge clock);
      cnt++;
    end
    check("settle_pos", {24'd0, pos0}, {24'd0, v});
    check("settle_busy", {31'd0, busy0}, 32'd0);
    check("settle_at_target", {31'd0, at0}, 32'd1);
  endtask

  initial begin
    int cyc;
    int cnt;
    // 1. reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", {31'd0, cmd_ready0}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_pos", {24'd0, pos0}, 32'd125);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_at_target", {31'd0, at0}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready0}, 32'd1);
    @(negedge clock);
    fork
      monitor();
    join_none

    // 2. command 130: ramp up one unit per 4 clocks
    push_range(126, 130);
    send_cmd(8'd130);
    @(negedge clock);
    check("ramp_busy", {31'd0, busy0}, 32'd1);
`ifdef SERVO_RAMP_PREEMPT_EN
    check("ramp_ready", {31'd0, cmd_ready0}, 32'd1);
`else
    check("ramp_ready", {31'd0, cmd_ready0}, 32'd0);
`endif
    wait_pos(8'd126, cyc);
    wait_pos(8'd127, cyc);
    check("tick_period", cyc, 32'd4);
    wait_idle(8'd130);

    // 3. clamp high, then back to 125, then a command equal to pos_out
    push_range(131, 250);
    send_cmd(8'd255);
    wait_idle(8'd250);
    check("clamp_target", {24'd0, u0.target_q}, 32'd250);
    repeat (20) @(negedge clock);
    check("clamp_hold", {24'd0, pos0}, 32'd250);
    push_range(249, 125);
    send_cmd(8'd125);
    wait_idle(8'd125);
    send_cmd(8'd125);
    repeat (6) @(negedge clock);
    check("same_cmd_busy", {31'd0, busy0}, 32'd0);
    check("same_cmd_pos", {24'd0, pos0}, 32'd125);

    // 4. buttons: up for exactly 3 ticks, then both held
    push_range(126, 128);
    btn_up0 = 1'b1;
    repeat (12) @(negedge clock);
    btn_dn0 = 1'b1;
    repeat (12) @(negedge clock);
    check("btn_both_target", {24'd0, u0.target_q}, 32'd128);
    btn_up0 = 1'b0;
    btn_dn0 = 1'b0;
    wait_idle(8'd128);

    // 5. reset from 128, then reset mid-ramp at 127
    exp_q.push_back(8'd125);
    rst = 1'b1;
    @(negedge clock);
    check("rst2_pos", {24'd0, pos0}, 32'd125);
    check("rst2_ready", {31'd0, cmd_ready0}, 32'd0);
    rst = 1'b0;
    @(negedge clock);
    push_range(126, 127);
    send_cmd(8'd130);
    wait_pos(8'd127, cyc);
    exp_q.push_back(8'd125);
    rst = 1'b1;
    @(negedge clock);
    check("midrst_pos", {24'd0, pos0}, 32'd125);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_tick", {30'd0, u0.tick_cnt_q}, 32'd0);
    check("midrst_target", {24'd0, u0.target_q}, 32'd125);
    rst = 1'b0;
    @(negedge clock);

    // 6. command 200, then command 100 issued at pos_out=130
    push_range(126, 130);
    send_cmd(8'd200);
    wait_pos(8'd130, cyc);
`ifdef SERVO_RAMP_PREEMPT_EN
    check("preempt_ready", {31'd0, cmd_ready0}, 32'd1);
    push_range(129, 100);
`else
    check("blocked_ready", {31'd0, cmd_ready0}, 32'd0);
    push_range(131, 200);
    push_range(199, 100);
`endif
    send_cmd(8'd100);
    wait_idle(8'd100);

    // 3b. POS_MIN=20 instance: command 0 clamps to 20
    c1_pos   = 8'd0;
    c1_valid = 1'b1;
    check("u1_ready", {31'd0, c1_ready}, 32'd1);
    @(posedge clock);
    #1;
    c1_valid = 1'b0;
    cnt = 0;
    @(negedge clock);
    check("u1_target", {24'd0, u1.target_q}, 32'd20);
    while (!(pos1 === 8'd20 && busy1 === 1'b0) && cnt < 3000) begin
      @(negedge clock);
      cnt++;
    end
    repeat (12) @(negedge clock);
    check("u1_pos_min", {24'd0, pos1}, 32'd20);
    check("u1_at_target", {31'd0, at1}, 32'd1);

    repeat (8) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
